// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its downstream key decoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      WAIT_REL
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'd12;
   localparam logic [3:0] KEY_HASH = 4'd14;
   localparam logic [3:0] KEY_OP0  = 4'd3;
   localparam logic [3:0] KEY_OP1  = 4'd7;
   localparam logic [3:0] KEY_OP2  = 4'd11;
   localparam logic [3:0] KEY_OP3  = 4'd15;

   // Index of the lowest zero bit; used for both the active column and the pressed row.
   function automatic logic [1:0] lowest_zero(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick on the last clock of every SCAN_DIV-cycle column step.
module scan_tick_gen #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronisation, press/release debounce, one strobe per press.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   // One extra bit of headroom so the counter can actually hold DEBOUNCE_CNT.
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT);

   logic [3:0]    row_meta;
   logic [3:0]    row_s;
   logic          tick;
   state_t        state;
   logic [DW-1:0] db_cnt;
   logic [1:0]    row_idx;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta <= 4'hF;
         row_s    <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_s    <= row_meta;
      end
   end

   // The column is frozen from detection until the release is accepted, so the
   // active column at accept time is the column of the captured key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         col_out   <= 4'b1110;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         db_cnt    <= '0;
         row_idx   <= 2'd0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (tick) begin
                  if (row_s == 4'hF) begin
                     col_out <= {col_out[2:0], col_out[3]};
                  end else begin
                     row_idx <= lowest_zero(row_s);
                     db_cnt  <= DW'(1);
                     if (DEBOUNCE_CNT <= 1) begin
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        key_code  <= {lowest_zero(row_s), lowest_zero(col_out)};
                        state     <= EMIT;
                     end else begin
                        state <= DEBOUNCE;
                     end
                  end
               end
            end
            DEBOUNCE: begin
               if (tick) begin
                  if (!row_s[row_idx]) begin
                     db_cnt <= db_cnt + 1'b1;
                     if (db_cnt + 1'b1 == DB_LAST) begin
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        key_code  <= {row_idx, lowest_zero(col_out)};
                        state     <= EMIT;
                     end
                  end else begin
                     db_cnt <= '0;
                     state  <= SCAN;
                  end
               end
            end
            EMIT: begin
               db_cnt <= '0;
               state  <= WAIT_REL;
            end
            WAIT_REL: begin
               if (tick) begin
                  if (row_s != 4'hF) begin
                     db_cnt <= '0;
                  end else if (db_cnt + 1'b1 == DB_LAST) begin
                     db_cnt   <= '0;
                     key_held <= 1'b0;
                     col_out  <= {col_out[2:0], col_out[3]};
                     state    <= SCAN;
                  end else begin
                     db_cnt <= db_cnt + 1'b1;
                  end
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple switch-matrix model (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   // Bit r*4+c set means key (row r, col c) is held down; that index is also its key code.
   logic [15:0] pressed = 16'h0000;

   int          vectors    = 0;
   int          miscompares = 0;
   int          pulses     = 0;
   logic [3:0]  last_code  = 4'd0;
   logic        bad_col    = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_out[c])
               row_in[r] = 1'b0;
   end

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always @(negedge clk) begin
      if (key_valid) begin
         pulses    = pulses + 1;
         last_code = key_code;
      end
      if (!(col_out inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}))
         bad_col = 1'b1;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] mask, input int cycles);
      pressed = mask;
      waitCycles(cycles);
   endtask

   // Waits for col_out to step onto target (leaving it first if already there).
   task automatic waitColEdge(input string tag, input logic [3:0] target, input int budget);
      int n = 0;
      while (col_out == target && n < budget) begin
         waitCycles(1);
         n++;
      end
      while (col_out != target && n < budget) begin
         waitCycles(1);
         n++;
      end
      checkOutput(tag, {4'd0, col_out}, {4'd0, target});
   endtask

   task automatic waitHeldLow(input string tag, input int budget);
      int n = 0;
      while (key_held && n < budget) begin
         waitCycles(1);
         n++;
      end
      checkOutput(tag, {7'd0, key_held}, 8'd0);
   endtask

   initial begin
      rst = 1'b1;
      waitCycles(3);
      checkOutput("rst_col", {4'd0, col_out}, 8'h0E);
      checkOutput("rst_valid", {7'd0, key_valid}, 8'd0);
      checkOutput("rst_held", {7'd0, key_held}, 8'd0);
      checkOutput("rst_code", {4'd0, key_code}, 8'd0);
      rst = 1'b0;

      // Idle rotation, one step every 4 clocks
      waitColEdge("rot_1101", 4'b1101, 10);
      waitCycles(4);
      checkOutput("rot_1011", {4'd0, col_out}, 8'h0B);
      waitCycles(4);
      checkOutput("rot_0111", {4'd0, col_out}, 8'h07);
      waitCycles(4);
      checkOutput("rot_1110", {4'd0, col_out}, 8'h0E);

      // Steady press of (1,2)
      applyStimulus(16'h0040, 200);
      checkOutput("k6_pulses", 8'(pulses), 8'd1);
      checkOutput("k6_code", {4'd0, last_code}, 8'd6);
      checkOutput("k6_held", {7'd0, key_held}, 8'd1);
      applyStimulus(16'h0000, 4);
      checkOutput("k6_held_after_rel", {7'd0, key_held}, 8'd1);
      waitHeldLow("k6_release", 30);
      checkOutput("k6_pulses_end", 8'(pulses), 8'd1);

      // Bounce on (0,0): seen for two ticks only
      waitColEdge("bounce_sync", 4'b1110, 40);
      applyStimulus(16'h0001, 8);
      applyStimulus(16'h0000, 20);
      checkOutput("bounce_pulses", 8'(pulses), 8'd1);
      checkOutput("bounce_held", {7'd0, key_held}, 8'd0);
      waitColEdge("bounce_resume", 4'b1101, 40);

      // (3,2) with a short release glitch, then a clean release and re-press
      applyStimulus(16'h4000, 100);
      checkOutput("k14_pulses", 8'(pulses), 8'd2);
      checkOutput("k14_code", {4'd0, last_code}, 8'd14);
      applyStimulus(16'h0000, 8);
      applyStimulus(16'h4000, 60);
      checkOutput("glitch_pulses", 8'(pulses), 8'd2);
      checkOutput("glitch_held", {7'd0, key_held}, 8'd1);
      applyStimulus(16'h0000, 40);
      checkOutput("k14_released", {7'd0, key_held}, 8'd0);
      applyStimulus(16'h4000, 100);
      checkOutput("k14b_pulses", 8'(pulses), 8'd3);
      checkOutput("k14b_code", {4'd0, last_code}, 8'd14);
      applyStimulus(16'h0000, 40);

      // Two rows in column 1: lowest row wins, the other is ignored until full release
      applyStimulus(16'h0202, 100);
      checkOutput("multi_pulses", 8'(pulses), 8'd4);
      checkOutput("multi_code", {4'd0, last_code}, 8'd1);
      applyStimulus(16'h0200, 100);
      checkOutput("multi_row2_pulses", 8'(pulses), 8'd4);
      checkOutput("multi_row2_held", {7'd0, key_held}, 8'd1);
      applyStimulus(16'h0000, 40);
      checkOutput("multi_released", {7'd0, key_held}, 8'd0);
      checkOutput("multi_pulses_end", 8'(pulses), 8'd4);

      // Reset in the middle of debouncing (1,1)
      waitColEdge("rstdb_sync", 4'b1101, 40);
      applyStimulus(16'h0020, 6);
      rst = 1'b1;
      waitCycles(3);
      checkOutput("rstdb_valid", {7'd0, key_valid}, 8'd0);
      checkOutput("rstdb_col", {4'd0, col_out}, 8'h0E);
      checkOutput("rstdb_pulses", 8'(pulses), 8'd4);
      rst = 1'b0;
      applyStimulus(16'h0020, 100);
      checkOutput("k5_pulses", 8'(pulses), 8'd5);
      checkOutput("k5_code", {4'd0, last_code}, 8'd5);
      checkOutput("k5_held", {7'd0, key_held}, 8'd1);
      applyStimulus(16'h0000, 40);
      checkOutput("k5_released", {7'd0, key_held}, 8'd0);

      checkOutput("col_onehot", {7'd0, bad_col}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
